// File: rtl/bcd2_stopwatch_ctrl.sv
// Stopwatch sequencer for a 2-digit BCD up-counter: start/pause/lap/clear control, tick prescaler, lap freeze.
// Optional build macro BCD2_SATURATE_EN: stop at 99 in a HALT state instead of wrapping.
module bcd2_stopwatch_ctrl #(
   parameter int PRESCALE = 10,
   parameter int PSW      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       lap_clear,
   input  logic [7:0] cnt_val,
   output logic       cnt_x,
   output logic       cnt_clr,
   output logic [7:0] disp_out,
   output logic       running,
   output logic       ovf
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      LAP   = 3'd2,
      PAUSE = 3'd3
`ifdef BCD2_SATURATE_EN
      ,HALT = 3'd4
`endif
   } state_t;

   localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);

   state_t         state, state_nxt;
   logic [PSW-1:0] presc, presc_nxt;
   logic [7:0]     lap_reg;
   logic           lap_ld;
   logic           x_nxt;
   logic           clr_nxt;
   logic           counting;
   logic           tick_due;
   logic           sat_hit;

   assign counting = (state == RUN) || (state == LAP);
   assign tick_due = counting && (presc == PRESC_LAST);

`ifdef BCD2_SATURATE_EN
   assign sat_hit = tick_due && (cnt_val == 8'h99);
`else
   assign sat_hit = 1'b0;
`endif

   // start_stop has priority over lap_clear in every state that reacts to both.
   always_comb begin
      state_nxt = state;
      clr_nxt   = 1'b0;
      lap_ld    = 1'b0;
      case (state)
         IDLE: begin
            if (start_stop)     state_nxt = RUN;
            else if (lap_clear) clr_nxt = 1'b1;
         end
         RUN: begin
`ifdef BCD2_SATURATE_EN
            if (sat_hit)        state_nxt = HALT;
            else
`endif
            if (start_stop)     state_nxt = PAUSE;
            else if (lap_clear) begin
               state_nxt = LAP;
               lap_ld    = 1'b1;
            end
         end
         LAP: begin
`ifdef BCD2_SATURATE_EN
            if (sat_hit)        state_nxt = HALT;
            else
`endif
            if (start_stop)     state_nxt = PAUSE;
            else if (lap_clear) state_nxt = RUN;
         end
         PAUSE: begin
            if (start_stop)     state_nxt = RUN;
            else if (lap_clear) begin
               state_nxt = IDLE;
               clr_nxt   = 1'b1;
            end
         end
`ifdef BCD2_SATURATE_EN
         HALT: begin
            if (lap_clear) begin
               state_nxt = IDLE;
               clr_nxt   = 1'b1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // A due tick is issued even when a pause lands on the same edge.
   always_comb begin
      x_nxt     = tick_due && !sat_hit;
      presc_nxt = presc;
      if (state_nxt == IDLE)  presc_nxt = '0;
      else if (tick_due)      presc_nxt = '0;
      else if (counting)      presc_nxt = presc + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         presc   <= '0;
         lap_reg <= 8'h00;
         cnt_x   <= 1'b0;
         cnt_clr <= 1'b0;
      end else begin
         state   <= state_nxt;
         presc   <= presc_nxt;
         cnt_x   <= x_nxt;
         cnt_clr <= clr_nxt;
         if (lap_ld) lap_reg <= cnt_val;
      end
   end

`ifdef BCD2_SATURATE_EN
   assign ovf = 1'b0;
`else
   logic ovf_q;

   // The counter wraps on the edge after a tick seen at 99.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           ovf_q <= 1'b0;
      else if (clr_nxt)                    ovf_q <= 1'b0;
      else if (cnt_x && cnt_val == 8'h99)  ovf_q <= 1'b1;
   end

   assign ovf = ovf_q;
`endif

   assign disp_out = (state == LAP) ? lap_reg : cnt_val;
   assign running  = counting;

endmodule

// File: tb/tb_bcd2_stopwatch_ctrl.sv
// Bench for bcd2_stopwatch_ctrl with a behavioural bcd2 counter in the loop; tick cycles are scoreboarded.
// Build with BCD2_SATURATE_EN defined to exercise the saturating variant.
module tb_bcd2_stopwatch_ctrl;

   localparam int P = 10;

   logic       clk;
   logic       rst;
   logic       start_stop;
   logic       lap_clear;
   logic [7:0] cnt_val;
   logic       cnt_x;
   logic       cnt_clr;
   logic [7:0] disp_out;
   logic       running;
   logic       ovf;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   logic [31:0] exp_q[$];

   bcd2_stopwatch_ctrl #(.PRESCALE(P), .PSW(4)) dut (
      .clk        (clk),
      .reset      (rst),
      .start_stop (start_stop),
      .lap_clear  (lap_clear),
      .cnt_val    (cnt_val),
      .cnt_x      (cnt_x),
      .cnt_clr    (cnt_clr),
      .disp_out   (disp_out),
      .running    (running),
      .ovf        (ovf)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // bcd2 counter model driven by the DUT strobes
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd9) return 8'h00;
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst)          cnt_val <= 8'h00;
      else if (cnt_clr) cnt_val <= 8'h00;
      else if (cnt_x)   cnt_val <= bcd_inc(cnt_val);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // scoreboard: each cnt_x pulse must match the next expected tick edge
   always @(negedge clk) begin
      if (!rst && cnt_x === 1'b1) begin
         if (exp_q.size() == 0) chk("tick_unexpected", 32'(cyc), 32'hffff_ffff);
         else                   chk("tick_cycle", 32'(cyc), exp_q.pop_front());
      end
   end

   // driver tasks (called at a negedge; command lands on edge e)
   task automatic pulse(input logic ss, input logic lc, output int e);
      start_stop = ss;
      lap_clear  = lc;
      e = cyc + 1;
      @(negedge clk);
      start_stop = 1'b0;
      lap_clear  = 1'b0;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic push_ticks(input int base, input int k0, input int k1);
      for (int k = k0; k <= k1; k++) exp_q.push_back(32'(base + P * k));
   endtask

   int e, s, c;

   initial begin
      rst = 1'b1;
      start_stop = 1'b0;
      lap_clear  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cnt_x", cnt_x, 0);
      chk("rst_cnt_clr", cnt_clr, 0);
      chk("rst_running", running, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_disp", disp_out, 8'h00);
      rst = 1'b0;
      @(negedge clk);

      // fresh start, ticks every P cycles, pause on the terminal count
      pulse(1, 0, e);
      push_ticks(e, 1, 4);
      chk("s1_running", running, 1);
      wait_until(e + 11);
      chk("s1_disp01", disp_out, 8'h01);
      wait_until(e + 21);
      chk("s1_disp02", disp_out, 8'h02);
      wait_until(e + 39);
      pulse(1, 0, s);
      chk("s1_pause_running", running, 0);
      chk("s1_pause_tick", cnt_x, 1);
      @(negedge clk);
      chk("s1_disp04", disp_out, 8'h04);
      repeat (20) @(negedge clk);
      chk("s1_held04", disp_out, 8'h04);

      // clear from PAUSE, then lap freeze at 37
      pulse(0, 1, c);
      chk("s2_clr_pulse", cnt_clr, 1);
      @(negedge clk);
      chk("s2_clr_done", cnt_clr, 0);
      chk("s2_disp00", disp_out, 8'h00);
      pulse(1, 0, e);
      push_ticks(e, 1, 40);
      wait_until(e + 374);
      pulse(0, 1, s);
      chk("s2_lap_disp", disp_out, 8'h37);
      chk("s2_lap_running", running, 1);
      wait_until(e + 391);
      chk("s2_lap_frozen", disp_out, 8'h37);
      wait_until(e + 394);
      pulse(0, 1, s);
      chk("s2_live_disp", disp_out, 8'h39);
      wait_until(e + 402);
      pulse(1, 0, s);
      chk("s2_paused", running, 0);
      chk("s2_disp40", disp_out, 8'h40);

      // long pause, resume completes the remaining prescale count, clear
      repeat (50) @(negedge clk);
      chk("s3_held40", disp_out, 8'h40);
      pulse(1, 0, s);
      push_ticks(s - 3, 1, 2);
      wait_until(s + 18);
      chk("s3_disp42", disp_out, 8'h42);
      wait_until(s + 19);
      pulse(1, 0, c);
      pulse(0, 1, c);
      chk("s3_clr_pulse", cnt_clr, 1);
      chk("s3_ovf", ovf, 0);
      @(negedge clk);
      chk("s3_clr_done", cnt_clr, 0);
      chk("s3_disp00", disp_out, 8'h00);

      // run to 99 and beyond
      pulse(1, 0, e);
      push_ticks(e, 1, 99);
      wait_until(e + 991);
      chk("s4_disp99", disp_out, 8'h99);
      chk("s4_ovf_pre", ovf, 0);
`ifdef BCD2_SATURATE_EN
      wait_until(e + 1001);
      chk("s4_sat_disp", disp_out, 8'h99);
      chk("s4_sat_running", running, 0);
      chk("s4_sat_ovf", ovf, 0);
      pulse(1, 0, s);
      chk("s4_halt_ignores_ss", running, 0);
      repeat (15) @(negedge clk);
      chk("s4_halt_disp", disp_out, 8'h99);
      pulse(0, 1, c);
      chk("s4_clr_pulse", cnt_clr, 1);
      @(negedge clk);
      chk("s4_disp00", disp_out, 8'h00);
`else
      push_ticks(e, 100, 101);
      wait_until(e + 1001);
      chk("s4_wrap_disp", disp_out, 8'h00);
      chk("s4_ovf_set", ovf, 1);
      wait_until(e + 1011);
      chk("s4_disp01", disp_out, 8'h01);
      chk("s4_ovf_sticky", ovf, 1);
      pulse(1, 0, s);
      pulse(0, 1, c);
      chk("s4_clr_pulse", cnt_clr, 1);
      chk("s4_ovf_cleared", ovf, 0);
      @(negedge clk);
      chk("s4_disp00", disp_out, 8'h00);
`endif

      // both commands in RUN: pause wins, no lap
      pulse(1, 0, e);
      push_ticks(e, 1, 2);
      wait_until(e + 24);
      pulse(1, 1, s);
      chk("s5_running", running, 0);
      chk("s5_disp_live", disp_out, 8'h02);
      pulse(1, 0, s);
      exp_q.push_back(32'(s + 5));
      wait_until(s + 6);
      chk("s5_disp03", disp_out, 8'h03);
      chk("s5_resumed", running, 1);

      // reset on the cycle a tick is due
      wait_until(s + 14);
      rst = 1'b1;
      #1;
      chk("s6_cnt_x", cnt_x, 0);
      chk("s6_running", running, 0);
      chk("s6_disp", disp_out, 8'h00);
      chk("s6_ovf", ovf, 0);
      chk("s6_cnt_clr", cnt_clr, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("s6_idle", running, 0);
      chk("q_empty", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
